vga_overlay_painter: RTL

- Parametrised successor of the frame painter FSM that feeds the VGA adapter's pixel-write port.
- Once per frame, on the falling edge of V_SYNC, it:
  - streams a full background image from an external ROM;
  - optionally draws a row of NUM_DIGITS BCD glyphs from a shared digit-glyph ROM;
  - draws a solid square cursor at the latched mouse position.
- ROMs sit outside the block. Background ROM selection by screen is done upstream. The block only drives addresses and consumes 1-cycle-latency read data.

---
 rtl/vga_overlay_painter.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_overlay_painter.sv
// Once-per-frame painter feeding the VGA pixel-write port: background raster, optional
// BCD glyph row, then a clipped square cursor, through a one-stage address->pixel pipeline.
module vga_overlay_painter #(
    parameter int SCREEN_W     = 320,
    parameter int SCREEN_H     = 240,
    parameter int NUM_DIGITS   = 4,
    parameter int GLYPH_W      = 18,
    parameter int GLYPH_H      = 18,
    parameter int DIGIT_X0     = 120,
    parameter int DIGIT_Y0     = 155,
    parameter int CURSOR_SIZE  = 4,
    parameter int CURSOR_COLOR = 0,
    parameter int COLOR_W      = 3,
    parameter int LEAD_BLANK   = 1
) (
    input  logic                    clk,
    input  logic                    iReset,
    input  logic                    V_SYNC,
    input  logic                    digits_en,
    input  logic [4*NUM_DIGITS-1:0] bcd,
    input  logic [8:0]              mouse_x,
    input  logic [7:0]              mouse_y,
    output logic [16:0]             bg_addr,
    input  logic [COLOR_W-1:0]      bg_q,
    output logic [12:0]             glyph_addr,
    input  logic [COLOR_W-1:0]      glyph_q,
    output logic [8:0]              x,
    output logic [7:0]              y,
    output logic [COLOR_W-1:0]      color,
    output logic                    writeEn,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun
);

    typedef enum logic [2:0] {ST_IDLE, ST_BG, ST_DIGITS, ST_CURSOR, ST_DONE} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_BG, SRC_GLYPH, SRC_CURSOR} src_t;

    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [8:0]         BG_X_LAST  = 9'(SCREEN_W - 1);
    localparam logic [7:0]         BG_Y_LAST  = 8'(SCREEN_H - 1);
    localparam logic [8:0]         GL_X_LAST  = 9'(GLYPH_W - 1);
    localparam logic [7:0]         GL_Y_LAST  = 8'(GLYPH_H - 1);
    localparam logic [8:0]         CUR_X_LAST = 9'(CURSOR_SIZE - 1);
    localparam logic [7:0]         CUR_Y_LAST = 8'(CURSOR_SIZE - 1);
    localparam logic [8:0]         HALF_X     = 9'(CURSOR_SIZE / 2);
    localparam logic [7:0]         HALF_Y     = 8'(CURSOR_SIZE / 2);
    localparam logic [9:0]         SCREEN_W_L = 10'(SCREEN_W);
    localparam logic [8:0]         SCREEN_H_L = 9'(SCREEN_H);
    localparam logic [8:0]         DIGIT_X0_L = 9'(DIGIT_X0);
    localparam logic [7:0]         DIGIT_Y0_L = 8'(DIGIT_Y0);
    localparam logic [8:0]         GLYPH_W_L  = 9'(GLYPH_W);
    localparam logic [12:0]        GLYPH_AREA = 13'(GLYPH_W * GLYPH_H);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_W-1:0]  SLOT_ONE   = SLOT_W'(1);
    localparam logic [COLOR_W-1:0] CUR_COLOR  = COLOR_W'(CURSOR_COLOR);

    // Slot 0 is the most significant nibble.
    function automatic logic [3:0] nibble_at(input logic [4*NUM_DIGITS-1:0] v, input int s);
        return v[4*(NUM_DIGITS-1-s) +: 4];
    endfunction

    function automatic logic [12:0] glyph_base(input logic [3:0] nib);
        return {9'd0, nib} * GLYPH_AREA;
    endfunction

    // A slot is drawn unless its nibble is invalid BCD or it is a leading zero (last slot always shown).
    function automatic logic [NUM_DIGITS-1:0] slot_mask(input logic [4*NUM_DIGITS-1:0] v);
        logic [NUM_DIGITS-1:0] m;
        logic                  leading;
        logic [3:0]            nib;
        m       = {NUM_DIGITS{1'b0}};
        leading = 1'b1;
        for (int s = 0; s < NUM_DIGITS; s++) begin
            nib = nibble_at(v, s);
            if (nib > 4'd9) begin
                m[s] = 1'b0;
            end else if ((LEAD_BLANK != 0) && (nib == 4'd0) && leading && (s < NUM_DIGITS - 1)) begin
                m[s] = 1'b0;
            end else begin
                m[s] = 1'b1;
            end
            if (nib != 4'd0) begin
                leading = 1'b0;
            end
        end
        return m;
    endfunction

    state_t                  state_r;
    src_t                    src_r;
    logic                    vs_prev_r, digits_en_r;
    logic [4*NUM_DIGITS-1:0] bcd_r;
    logic [NUM_DIGITS-1:0]   mask_r;
    logic [8:0]              ox_r, cx_r, slot_x_r, px_r;
    logic [7:0]              oy_r, cy_r, py_r;
    logic [SLOT_W-1:0]       slot_r;
    logic [16:0]             bg_addr_r;
    logic [12:0]             glyph_addr_r;
    logic                    we_r, busy_r, frame_done_r, overrun_r;
    logic                    frame_start_s;
    logic [9:0]              cur_x_s;
    logic [8:0]              cur_y_s;

    assign frame_start_s = vs_prev_r & ~V_SYNC;
    // Widened so off-screen cursor cells are clipped rather than wrapped.
    assign cur_x_s = {1'b0, ox_r} + {1'b0, cx_r};
    assign cur_y_s = {1'b0, oy_r} + {1'b0, cy_r};

    // Frame FSM: stage 0 scan counters/addresses and stage 1 pixel registers.
    always_ff @(posedge clk) begin
        if (iReset) begin
            state_r      <= ST_IDLE;
            src_r        <= SRC_NONE;
            vs_prev_r    <= 1'b1;
            digits_en_r  <= 1'b0;
            bcd_r        <= {(4*NUM_DIGITS){1'b0}};
            mask_r       <= {NUM_DIGITS{1'b0}};
            ox_r         <= 9'd0;
            oy_r         <= 8'd0;
            cx_r         <= 9'd0;
            cy_r         <= 8'd0;
            slot_r       <= {SLOT_W{1'b0}};
            slot_x_r     <= 9'd0;
            bg_addr_r    <= 17'd0;
            glyph_addr_r <= 13'd0;
            px_r         <= 9'd0;
            py_r         <= 8'd0;
            we_r         <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            vs_prev_r    <= V_SYNC;
            overrun_r    <= frame_start_s && (state_r != ST_IDLE);
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    we_r  <= 1'b0;
                    src_r <= SRC_NONE;
                    if (frame_start_s) begin
                        digits_en_r  <= digits_en;
                        bcd_r        <= bcd;
                        mask_r       <= slot_mask(bcd);
                        ox_r         <= (mouse_x >= HALF_X) ? (mouse_x - HALF_X) : 9'd0;
                        oy_r         <= (mouse_y >= HALF_Y) ? (mouse_y - HALF_Y) : 8'd0;
                        cx_r         <= 9'd0;
                        cy_r         <= 8'd0;
                        slot_r       <= {SLOT_W{1'b0}};
                        bg_addr_r    <= 17'd0;
                        glyph_addr_r <= 13'd0;
                        busy_r       <= 1'b1;
                        state_r      <= ST_BG;
                    end
                end
                ST_BG: begin
                    px_r  <= cx_r;
                    py_r  <= cy_r;
                    we_r  <= 1'b1;
                    src_r <= SRC_BG;
                    if (cx_r == BG_X_LAST) begin
                        cx_r <= 9'd0;
                        if (cy_r == BG_Y_LAST) begin
                            cy_r         <= 8'd0;
                            slot_r       <= {SLOT_W{1'b0}};
                            slot_x_r     <= DIGIT_X0_L;
                            glyph_addr_r <= glyph_base(nibble_at(bcd_r, 0));
                            state_r      <= digits_en_r ? ST_DIGITS : ST_CURSOR;
                        end else begin
                            cy_r      <= cy_r + 8'd1;
                            bg_addr_r <= bg_addr_r + 17'd1;
                        end
                    end else begin
                        cx_r      <= cx_r + 9'd1;
                        bg_addr_r <= bg_addr_r + 17'd1;
                    end
                end
                ST_DIGITS: begin
                    px_r  <= slot_x_r + cx_r;
                    py_r  <= DIGIT_Y0_L + cy_r;
                    we_r  <= mask_r[slot_r];
                    src_r <= SRC_GLYPH;
                    if (cx_r == GL_X_LAST) begin
                        cx_r <= 9'd0;
                        if (cy_r == GL_Y_LAST) begin
                            cy_r <= 8'd0;
                            if (slot_r == SLOT_LAST) begin
                                state_r <= ST_CURSOR;
                            end else begin
                                slot_r       <= slot_r + SLOT_ONE;
                                slot_x_r     <= slot_x_r + GLYPH_W_L;
                                glyph_addr_r <= glyph_base(nibble_at(bcd_r, int'(slot_r) + 1));
                            end
                        end else begin
                            cy_r         <= cy_r + 8'd1;
                            glyph_addr_r <= glyph_addr_r + 13'd1;
                        end
                    end else begin
                        cx_r         <= cx_r + 9'd1;
                        glyph_addr_r <= glyph_addr_r + 13'd1;
                    end
                end
                ST_CURSOR: begin
                    px_r  <= cur_x_s[8:0];
                    py_r  <= cur_y_s[7:0];
                    we_r  <= (cur_x_s < SCREEN_W_L) && (cur_y_s < SCREEN_H_L);
                    src_r <= SRC_CURSOR;
                    if (cx_r == CUR_X_LAST) begin
                        cx_r <= 9'd0;
                        if (cy_r == CUR_Y_LAST) begin
                            cy_r    <= 8'd0;
                            state_r <= ST_DONE;
                        end else begin
                            cy_r <= cy_r + 8'd1;
                        end
                    end else begin
                        cx_r <= cx_r + 9'd1;
                    end
                end
                ST_DONE: begin
                    we_r         <= 1'b0;
                    src_r        <= SRC_NONE;
                    frame_done_r <= 1'b1;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    we_r    <= 1'b0;
                    src_r   <= SRC_NONE;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Pixel colour follows the stage-1 source tag; ROM data is already aligned to it.
    always_comb begin
        color = {COLOR_W{1'b0}};
        case (src_r)
            SRC_BG:     color = bg_q;
            SRC_GLYPH:  color = glyph_q;
            SRC_CURSOR: color = CUR_COLOR;
            default:    color = {COLOR_W{1'b0}};
        endcase
    end

    assign bg_addr    = bg_addr_r;
    assign glyph_addr = glyph_addr_r;
    assign x          = px_r;
    assign y          = py_r;
    assign writeEn    = we_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign overrun    = overrun_r;

endmodule
